// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter: FSM state encoding
// and the byte-strobe value used for reads.
package sram_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_REQ  = 3'd1,
    ST_D_WAIT = 3'd2,
    ST_I_REQ  = 3'd3,
    ST_I_WAIT = 3'd4
  } arb_state_e;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;

endpackage

// File: rtl/sram_port_slot.sv
// Per-side completion tracker: remembers that an access finished and holds its
// read data until the pipeline advances past it.
module sram_port_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              complete,
  input  logic              is_read,
  input  logic [DATA_W-1:0] rdata_in,
  input  logic              pipe_stall,
  output logic              done,
  output logic [DATA_W-1:0] rdata_out
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (resetn) begin
      done      <= 1'b0;
      rdata_out <= '0;
    end else begin
      // A completion only sticks while the pipeline is frozen; once it advances
      // the result has been consumed and the flag must not block the next access.
      done <= pipe_stall & (done | complete);
      if (complete && is_read) begin
        rdata_out <= rdata_in;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Funnels the core's instruction and data SRAM ports onto one memory port,
// one outstanding transaction at a time, and drives the fetch/memory stalls.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter bit DATA_FIRST = 1'b1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_en,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_rdata,
  output logic              fetch_stall,
  input  logic              longest_stall_f,
  input  logic              data_en,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              memory_stall,
  input  logic              longest_stall_m,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [31:0]       mem_rdata
);

  arb_state_e state_q, state_d;
  logic       load_d, load_i;
  logic       i_done, d_done;
  logic       i_pend, d_pend, go_d;
  logic       i_complete, d_complete;

  assign i_pend = inst_en & ~i_done;
  assign d_pend = data_en & ~d_done;
  assign go_d   = d_pend & (DATA_FIRST | ~i_pend);

  always_ff @(posedge clk) begin
    if (resetn) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    load_i  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go_d) begin
          state_d = ST_D_REQ;
          load_d  = 1'b1;
        end else if (i_pend) begin
          state_d = ST_I_REQ;
          load_i  = 1'b1;
        end
      end
      ST_D_REQ:  if (mem_addr_ok) state_d = mem_data_ok ? ST_IDLE : ST_D_WAIT;
      ST_D_WAIT: if (mem_data_ok) state_d = ST_IDLE;
      ST_I_REQ:  if (mem_addr_ok) state_d = mem_data_ok ? ST_IDLE : ST_I_WAIT;
      ST_I_WAIT: if (mem_data_ok) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request fields are captured once at issue, so later core-side address
  // changes cannot disturb an accepted or in-flight request.
  always_ff @(posedge clk) begin
    if (resetn) begin
      mem_wr    <= 1'b0;
      mem_wstrb <= WSTRB_NONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (load_d) begin
      mem_wr    <= |data_wen;
      mem_wstrb <= data_wen;
      mem_addr  <= data_addr;
      mem_wdata <= data_wdata;
    end else if (load_i) begin
      mem_wr    <= 1'b0;
      mem_wstrb <= WSTRB_NONE;
      mem_addr  <= inst_addr;
    end
  end

  assign mem_req = (state_q == ST_D_REQ) || (state_q == ST_I_REQ);

  assign d_complete = mem_data_ok &
                      (((state_q == ST_D_REQ) & mem_addr_ok) | (state_q == ST_D_WAIT));
  assign i_complete = mem_data_ok &
                      (((state_q == ST_I_REQ) & mem_addr_ok) | (state_q == ST_I_WAIT));

  sram_port_slot #(.DATA_W(32)) u_inst_slot (
    .clk        (clk),
    .resetn     (resetn),
    .complete   (i_complete),
    .is_read    (1'b1),
    .rdata_in   (mem_rdata),
    .pipe_stall (longest_stall_f),
    .done       (i_done),
    .rdata_out  (inst_rdata)
  );

  // mem_wr is stable for the whole transaction, so it tells load from store.
  sram_port_slot #(.DATA_W(32)) u_data_slot (
    .clk        (clk),
    .resetn     (resetn),
    .complete   (d_complete),
    .is_read    (~mem_wr),
    .rdata_in   (mem_rdata),
    .pipe_stall (longest_stall_m),
    .done       (d_done),
    .rdata_out  (data_rdata)
  );

  assign fetch_stall  = ~resetn & inst_en & ~i_done;
  assign memory_stall = ~resetn & data_en & ~d_done;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed cycle-by-cycle bench for sram_port_arbiter; the bench plays both the
// core (enables, global stall) and the memory side (addr_ok/data_ok/rdata).
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        fetch_stall;
  logic        longest_stall_f;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        memory_stall;
  logic        longest_stall_m;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // The core freezes the whole pipeline whenever either side is stalled.
  assign longest_stall_f = fetch_stall | memory_stall;
  assign longest_stall_m = fetch_stall | memory_stall;

  sram_port_arbiter #(.DATA_FIRST(1'b1), .ADDR_W(32)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_en         (inst_en),
    .inst_addr       (inst_addr),
    .inst_rdata      (inst_rdata),
    .fetch_stall     (fetch_stall),
    .longest_stall_f (longest_stall_f),
    .data_en         (data_en),
    .data_wen        (data_wen),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_rdata      (data_rdata),
    .memory_stall    (memory_stall),
    .longest_stall_m (longest_stall_m),
    .mem_req         (mem_req),
    .mem_wr          (mem_wr),
    .mem_wstrb       (mem_wstrb),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_addr_ok     (mem_addr_ok),
    .mem_data_ok     (mem_data_ok),
    .mem_rdata       (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle; inputs are then changed 1 time unit after the
  // edge and outputs are sampled after a further settle delay (settle()).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic mem_idle();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
  endtask

  initial begin
    resetn = 1'b1;
    inst_en = 1'b1; inst_addr = 32'h0;
    data_en = 1'b1; data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;

    // ---- reset ----
    tick(); tick();
    settle();
    check("rst_fetch_stall", {31'b0, fetch_stall}, 32'd0);
    check("rst_memory_stall", {31'b0, memory_stall}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    check("rst_inst_rdata", inst_rdata, 32'h0);
    check("rst_data_rdata", data_rdata, 32'h0);
    tick();
    resetn = 1'b0; inst_en = 1'b0; data_en = 1'b0;
    tick();

    // ---- 1: fetch only ----
    inst_en = 1'b1; inst_addr = 32'h1FC0_0000; settle();
    check("t1_c0_stall", {31'b0, fetch_stall}, 32'd1);
    check("t1_c0_req", {31'b0, mem_req}, 32'd0);
    tick(); mem_addr_ok = 1'b1; settle();
    check("t1_c1_req", {31'b0, mem_req}, 32'd1);
    check("t1_c1_addr", mem_addr, 32'h1FC0_0000);
    check("t1_c1_wr", {31'b0, mem_wr}, 32'd0);
    check("t1_c1_stall", {31'b0, fetch_stall}, 32'd1);
    tick(); mem_idle(); settle();
    check("t1_c2_req", {31'b0, mem_req}, 32'd0);
    check("t1_c2_stall", {31'b0, fetch_stall}, 32'd1);
    tick(); mem_data_ok = 1'b1; mem_rdata = 32'h3C08_BFAF; settle();
    check("t1_c3_stall", {31'b0, fetch_stall}, 32'd1);
    tick(); mem_idle(); settle();
    check("t1_c4_stall", {31'b0, fetch_stall}, 32'd0);
    check("t1_c4_rdata", inst_rdata, 32'h3C08_BFAF);
    check("t1_c4_req", {31'b0, mem_req}, 32'd0);
    tick(); inst_en = 1'b0; settle();
    check("t1_c5_req", {31'b0, mem_req}, 32'd0);

    // ---- 2: simultaneous fetch and load, data first ----
    tick();
    inst_en = 1'b1; inst_addr = 32'h1FC0_0004;
    data_en = 1'b1; data_wen = 4'h0; data_addr = 32'h0000_0010; settle();
    check("t2_c0_fstall", {31'b0, fetch_stall}, 32'd1);
    check("t2_c0_mstall", {31'b0, memory_stall}, 32'd1);
    tick(); mem_addr_ok = 1'b1; settle();
    check("t2_c1_req", {31'b0, mem_req}, 32'd1);
    check("t2_c1_addr", mem_addr, 32'h0000_0010);
    check("t2_c1_wr", {31'b0, mem_wr}, 32'd0);
    tick(); mem_idle(); settle();
    check("t2_c2_req", {31'b0, mem_req}, 32'd0);
    tick(); mem_data_ok = 1'b1; mem_rdata = 32'h1111_2222; settle();
    check("t2_c3_mstall", {31'b0, memory_stall}, 32'd1);
    tick(); mem_idle(); settle();
    check("t2_c4_mstall", {31'b0, memory_stall}, 32'd0);
    check("t2_c4_drdata", data_rdata, 32'h1111_2222);
    check("t2_c4_fstall", {31'b0, fetch_stall}, 32'd1);
    check("t2_c4_req", {31'b0, mem_req}, 32'd0);
    tick(); mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h2408_0001; settle();
    check("t2_c5_req", {31'b0, mem_req}, 32'd1);
    check("t2_c5_addr", mem_addr, 32'h1FC0_0004);
    check("t2_c5_mstall_held", {31'b0, memory_stall}, 32'd0);
    tick(); mem_idle(); settle();
    check("t2_c6_fstall", {31'b0, fetch_stall}, 32'd0);
    check("t2_c6_irdata", inst_rdata, 32'h2408_0001);
    check("t2_c6_req", {31'b0, mem_req}, 32'd0);
    tick(); inst_en = 1'b0; data_en = 1'b0; settle();
    check("t2_c7_req", {31'b0, mem_req}, 32'd0);

    // ---- 3: store ----
    tick();
    data_en = 1'b1; data_wen = 4'b0011; data_wdata = 32'hDEAD_BEEF; data_addr = 32'h20; settle();
    check("t3_c0_mstall", {31'b0, memory_stall}, 32'd1);
    tick(); mem_addr_ok = 1'b1; settle();
    check("t3_c1_req", {31'b0, mem_req}, 32'd1);
    check("t3_c1_wr", {31'b0, mem_wr}, 32'd1);
    check("t3_c1_wstrb", {28'b0, mem_wstrb}, 32'h3);
    check("t3_c1_addr", mem_addr, 32'h20);
    check("t3_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hBAD0_BAD0; settle();
    check("t3_c2_mstall", {31'b0, memory_stall}, 32'd1);
    tick(); mem_idle(); settle();
    check("t3_c3_mstall", {31'b0, memory_stall}, 32'd0);
    check("t3_c3_drdata_kept", data_rdata, 32'h1111_2222);
    tick(); data_en = 1'b0; data_wen = 4'h0; settle();
    check("t3_c4_req", {31'b0, mem_req}, 32'd0);

    // ---- 4: fetch completes while load pending; i_done holds ----
    tick();
    inst_en = 1'b1; inst_addr = 32'h1FC0_0008; settle();
    tick(); mem_addr_ok = 1'b1; data_en = 1'b1; data_addr = 32'h30; settle();
    check("t4_c1_req", {31'b0, mem_req}, 32'd1);
    check("t4_c1_addr", mem_addr, 32'h1FC0_0008);
    tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h8C09_0000; settle();
    check("t4_c2_fstall", {31'b0, fetch_stall}, 32'd1);
    tick(); mem_idle(); settle();
    check("t4_c3_fstall", {31'b0, fetch_stall}, 32'd0);
    check("t4_c3_irdata", inst_rdata, 32'h8C09_0000);
    check("t4_c3_mstall", {31'b0, memory_stall}, 32'd1);
    tick(); mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h55AA_55AA; settle();
    check("t4_c4_req", {31'b0, mem_req}, 32'd1);
    check("t4_c4_addr_is_data", mem_addr, 32'h30);
    check("t4_c4_fstall_held", {31'b0, fetch_stall}, 32'd0);
    tick(); mem_idle(); settle();
    check("t4_c5_mstall", {31'b0, memory_stall}, 32'd0);
    check("t4_c5_drdata", data_rdata, 32'h55AA_55AA);
    check("t4_c5_req", {31'b0, mem_req}, 32'd0);
    tick(); inst_addr = 32'h1FC0_000C; data_en = 1'b0; settle();
    check("t4_c6_fstall", {31'b0, fetch_stall}, 32'd1);
    check("t4_c6_req", {31'b0, mem_req}, 32'd0);
    tick(); mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0123_4567; settle();
    check("t4_c7_req", {31'b0, mem_req}, 32'd1);
    check("t4_c7_addr", mem_addr, 32'h1FC0_000C);
    tick(); mem_idle(); settle();
    check("t4_c8_irdata", inst_rdata, 32'h0123_4567);
    tick(); inst_en = 1'b0; settle();

    // ---- 5: same-cycle addr_ok and data_ok ----
    tick();
    data_en = 1'b1; data_addr = 32'h40; settle();
    tick(); mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D; settle();
    check("t5_c1_req", {31'b0, mem_req}, 32'd1);
    check("t5_c1_mstall", {31'b0, memory_stall}, 32'd1);
    tick(); mem_idle(); settle();
    check("t5_c2_mstall", {31'b0, memory_stall}, 32'd0);
    check("t5_c2_req_idle", {31'b0, mem_req}, 32'd0);
    check("t5_c2_drdata", data_rdata, 32'hCAFE_F00D);
    tick(); data_en = 1'b0; settle();

    // ---- 6: reset asserted in D_WAIT ----
    tick();
    data_en = 1'b1; data_addr = 32'h50; settle();
    tick(); mem_addr_ok = 1'b1; settle();
    check("t6_c1_req", {31'b0, mem_req}, 32'd1);
    tick(); mem_idle(); resetn = 1'b1; settle();
    check("t6_c2_mstall_forced", {31'b0, memory_stall}, 32'd0);
    tick(); resetn = 1'b0; data_en = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h7777_7777; settle();
    check("t6_c3_req", {31'b0, mem_req}, 32'd0);
    check("t6_c3_drdata", data_rdata, 32'h0);
    check("t6_c3_irdata", inst_rdata, 32'h0);
    check("t6_c3_addr", mem_addr, 32'h0);
    tick(); mem_idle(); settle();
    check("t6_c4_drdata_ignored", data_rdata, 32'h0);
    check("t6_c4_req", {31'b0, mem_req}, 32'd0);
    check("t6_c4_mstall", {31'b0, memory_stall}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
